// File: rtl/abft_pkg.sv
// Shared defaults and state encoding for the ABFT checksum encoder.
package abft_pkg;
  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = DW_DEF + 2 * $clog2(N_DEF);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } abft_state_e;
endpackage

// File: rtl/abft_encoder_if.sv
// Element stream in, encoded word stream out; master = producer/consumer side, slave = encoder side.
interface abft_encoder_if #(
  parameter int DW = 8,
  parameter int CW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic          out_chk;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chk, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chk, out_last
  );
endinterface

// File: rtl/abft_chk_acc.sv
// Clearable, enabled running-sum accumulator; one cycle from enable to updated sum.
module abft_chk_acc #(
  parameter int W  = 10,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [AW-1:0] add,
  output logic [W-1:0]  sum
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + W'(add);
    end
  end
endmodule

// File: rtl/abft_encoder.sv
// ABFT encoder: buffers an N x N block, then streams it row-major with row/column/grand checksums; 1-cycle LOAD->EMIT latency, outputs held while out_ready=0.
// Optional ABFT_ENC_FAULT_INJ_EN adds inj_en/inj_idx to flip bit 0 of one emitted word.
module abft_encoder
  import abft_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  localparam int CW = DW + 2 * $clog2(N)
`ifdef ABFT_ENC_FAULT_INJ_EN
  , localparam int IJW = $clog2((N + 1) * (N + 1))
`endif
) (
  input logic         clk,
  input logic         rst,
  abft_encoder_if.slave bus
`ifdef ABFT_ENC_FAULT_INJ_EN
  , input logic           inj_en
  , input logic [IJW-1:0] inj_idx
`endif
);
  localparam int IW = $clog2(N);
  localparam int OW = $clog2(N + 1);
  localparam int RW = DW + IW;
  localparam logic [0:0]    ST_LOAD  = LOAD;
  localparam logic [0:0]    ST_EMIT  = EMIT;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [OW-1:0] OUT_END  = OW'(N);

  logic [0:0]    state;
  logic [IW-1:0] in_row, in_col;
  logic [OW-1:0] out_row, out_col;
  logic [IW-1:0] r_idx, c_idx;
  logic [DW-1:0] mem [N][N];
  logic [RW-1:0] row_sum [N];
  logic [RW-1:0] col_sum [N];
  logic [CW-1:0] total;
  logic          in_fire, out_fire, last_in, last_out;
  logic [CW-1:0] word;
  logic          word_chk, word_last;

  assign bus.in_ready  = (state == ST_LOAD);
  assign bus.out_valid = (state == ST_EMIT);
  assign in_fire  = bus.in_valid && (state == ST_LOAD);
  assign out_fire = bus.out_ready && (state == ST_EMIT);
  assign last_in  = in_fire && (in_row == LAST_IDX) && (in_col == LAST_IDX);
  assign last_out = out_fire && word_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      in_row  <= '0;
      in_col  <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      if (in_fire) begin
        if (in_col == LAST_IDX) begin
          in_col <= '0;
          in_row <= (in_row == LAST_IDX) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
        if (last_in) state <= ST_EMIT;
      end
      if (out_fire) begin
        if (out_col == OUT_END) begin
          out_col <= '0;
          out_row <= (out_row == OUT_END) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
        if (last_out) state <= ST_LOAD;
      end
    end
  end

  // Data buffer needs no reset: every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) mem[in_row][in_col] <= bus.in_data;
  end

  for (genvar g = 0; g < N; g++) begin : g_acc
    abft_chk_acc #(.W(RW), .AW(DW)) u_row (
      .clk (clk),
      .rst (rst),
      .clr (last_out),
      .en  (in_fire && (in_row == IW'(g))),
      .add (bus.in_data),
      .sum (row_sum[g])
    );
    abft_chk_acc #(.W(RW), .AW(DW)) u_col (
      .clk (clk),
      .rst (rst),
      .clr (last_out),
      .en  (in_fire && (in_col == IW'(g))),
      .add (bus.in_data),
      .sum (col_sum[g])
    );
  end

  abft_chk_acc #(.W(CW), .AW(DW)) u_tot (
    .clk (clk),
    .rst (rst),
    .clr (last_out),
    .en  (in_fire),
    .add (bus.in_data),
    .sum (total)
  );

  // Index N on either axis selects a checksum, so the truncated index is only used below N.
  assign r_idx = out_row[IW-1:0];
  assign c_idx = out_col[IW-1:0];

  always_comb begin
    word      = '0;
    word_chk  = 1'b0;
    word_last = 1'b0;
    if (state == ST_EMIT) begin
      word_chk  = (out_row == OUT_END) || (out_col == OUT_END);
      word_last = (out_row == OUT_END) && (out_col == OUT_END);
      if (word_last)               word = total;
      else if (out_row == OUT_END) word = CW'(col_sum[c_idx]);
      else if (out_col == OUT_END) word = CW'(row_sum[r_idx]);
      else                         word = CW'(mem[r_idx][c_idx]);
    end
  end

`ifdef ABFT_ENC_FAULT_INJ_EN
  logic           inj_q;
  logic [IJW-1:0] inj_idx_q;
  logic [IJW-1:0] out_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q     <= 1'b0;
      inj_idx_q <= '0;
      out_idx   <= '0;
    end else begin
      if (last_in) begin
        inj_q     <= inj_en;
        inj_idx_q <= inj_idx;
      end
      if (out_fire) out_idx <= last_out ? '0 : out_idx + 1'b1;
    end
  end

  // Corruption is applied only on the way out; the stored checksums stay clean.
  assign bus.out_data = word ^ CW'(inj_q && (state == ST_EMIT) && (out_idx == inj_idx_q));
`else
  assign bus.out_data = word;
`endif
  assign bus.out_chk  = word_chk;
  assign bus.out_last = word_last;
endmodule

// File: tb/tb_abft_encoder.sv
// Bench for abft_encoder: fixed vector table, multi-cycle corner sequences and randomized matrices vs a plain-arithmetic model.
module tb_abft_encoder;
  typedef logic [15:0][7:0] mat_t;
  typedef logic [3:0][11:0] sum4_t;
  typedef struct packed {
    mat_t         m;
    sum4_t        rs;
    sum4_t        cs;
    logic [11:0]  tot;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [13:0] got_q [$];

  abft_encoder_if #(.DW(8), .CW(12)) bus ();

`ifdef ABFT_ENC_FAULT_INJ_EN
  logic       inj_en  = 1'b0;
  logic [4:0] inj_idx = '0;
  abft_encoder dut (.clk(clk), .rst(rst), .bus(bus), .inj_en(inj_en), .inj_idx(inj_idx));
`else
  abft_encoder dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, required %0h", nm, idx, got, want);
    end
  endtask

  // Encoded stream laid out from a matrix and given sums: {chk,last,data}.
  function automatic void build_exp(input mat_t m, input sum4_t rs, input sum4_t cs,
                                    input logic [11:0] tot, output logic [13:0] ex [25]);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (r < 4 && c < 4)  ex[r*5+c] = {2'b00, 4'h0, m[r*4+c]};
        else if (r < 4)      ex[r*5+c] = {2'b10, rs[r]};
        else if (c < 4)      ex[r*5+c] = {2'b10, cs[c]};
        else                 ex[r*5+c] = {2'b11, tot};
      end
  endfunction

  function automatic void model(input mat_t m, output logic [13:0] ex [25]);
    int rsi [4], csi [4], toti;
    sum4_t rs, cs;
    toti = 0;
    for (int i = 0; i < 4; i++) begin rsi[i] = 0; csi[i] = 0; end
    for (int i = 0; i < 16; i++) begin
      rsi[i/4] += int'(m[i]);
      csi[i%4] += int'(m[i]);
      toti     += int'(m[i]);
    end
    for (int i = 0; i < 4; i++) begin rs[i] = 12'(rsi[i]); cs[i] = 12'(csi[i]); end
    build_exp(m, rs, cs, 12'(toti), ex);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    check("rst_out_word", 0, {bus.out_chk, bus.out_last, bus.out_data}, 32'd0);
  endtask

  task automatic load_matrix(input mat_t m, input int n, input int gap);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      check("load_out_valid", i, 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'($urandom_range(1));
      bus.in_valid  = ($urandom_range(99) >= gap);
      bus.in_data   = bus.in_valid ? m[i] : 8'($urandom);
      if (bus.in_valid && bus.in_ready) i++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (i < n) check("load_timeout", i, 32'(i), 32'(n));
    if (n == 16) begin
      check("emit_latency", 0, 32'(bus.out_valid), 32'd1);
      check("emit_in_ready", 0, 32'(bus.in_ready), 32'd0);
    end
  endtask

  // mode 0: always ready, 1: toggle, 2: random. noise drives in_valid during EMIT.
  task automatic collect(input int mode, input int max_words, input bit noise);
    bit          prev_stall = 0;
    bit          done = 0;
    bit          rdy;
    int          guard = 0;
    logic [14:0] prev_word = '0;
    got_q.delete();
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
      if (prev_stall)
        check("stall_hold", got_q.size(), {bus.out_valid, bus.out_chk, bus.out_last, bus.out_data}, prev_word);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2) == 1;
        default: rdy = 1'($urandom_range(1));
      endcase
      bus.out_ready = rdy;
      bus.in_valid  = noise ? 1'($urandom_range(1)) : 1'b0;
      bus.in_data   = 8'($urandom);
      if (bus.out_valid && rdy) begin
        got_q.push_back({bus.out_chk, bus.out_last, bus.out_data});
        if (bus.out_last || got_q.size() == max_words) done = 1;
      end
      prev_stall = bus.out_valid && !rdy;
      prev_word  = {bus.out_valid, bus.out_chk, bus.out_last, bus.out_data};
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (!done) check("emit_timeout", got_q.size(), 32'(got_q.size()), 32'(max_words));
    else if (got_q.size() < max_words || max_words == 25) begin
      check("back_to_load_valid", 0, 32'(bus.out_valid), 32'd0);
      check("back_to_load_ready", 0, 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic compare(input string nm, input logic [13:0] ex [25], input int n);
    check({nm, "_count"}, 0, 32'(got_q.size()), 32'(n));
    for (int k = 0; k < n && k < got_q.size(); k++) check(nm, k, 32'(got_q[k]), 32'(ex[k]));
  endtask

  initial begin
    vec_t        tbl [5];
    logic [13:0] ex [25];
    mat_t        rm;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      tbl[0].m[i] = 8'(i + 1);
      tbl[2].m[i] = 8'(16 - i);
    end
    tbl[0].rs = {12'd58, 12'd42, 12'd26, 12'd10};
    tbl[0].cs = {12'd40, 12'd36, 12'd32, 12'd28};
    tbl[0].tot = 12'd136;
    tbl[1].m = {16{8'hFF}};
    tbl[1].rs = {4{12'd1020}};
    tbl[1].cs = {4{12'd1020}};
    tbl[1].tot = 12'd4080;
    tbl[2].rs = {12'd10, 12'd26, 12'd42, 12'd58};
    tbl[2].cs = {12'd28, 12'd32, 12'd36, 12'd40};
    tbl[2].tot = 12'd136;
    tbl[3].m = '0;
    tbl[3].rs = '0;
    tbl[3].cs = '0;
    tbl[3].tot = '0;
    tbl[4].m = {16{8'd1}};
    tbl[4].rs = {4{12'd4}};
    tbl[4].cs = {4{12'd4}};
    tbl[4].tot = 12'd16;

    repeat (3) @(posedge clk);
    do_reset();

    for (int t = 0; t < 5; t++) begin
      build_exp(tbl[t].m, tbl[t].rs, tbl[t].cs, tbl[t].tot, ex);
      load_matrix(tbl[t].m, 16, 0);
      collect(0, 25, 1'b0);
      compare($sformatf("table%0d", t), ex, 25);
    end

    // Toggling out_ready with in_valid noise must give the identical stream.
    build_exp(tbl[0].m, tbl[0].rs, tbl[0].cs, tbl[0].tot, ex);
    load_matrix(tbl[0].m, 16, 0);
    collect(1, 25, 1'b1);
    compare("toggle_ready", ex, 25);

    // Reset after 10 emitted words; next all-ones matrix must be clean.
    load_matrix(tbl[0].m, 16, 0);
    collect(0, 10, 1'b0);
    compare("pre_reset_emit", ex, 10);
    do_reset();
    build_exp(tbl[4].m, tbl[4].rs, tbl[4].cs, tbl[4].tot, ex);
    load_matrix(tbl[4].m, 16, 0);
    collect(0, 25, 1'b0);
    compare("after_emit_reset", ex, 25);

    // Reset during LOAD discards the partial block.
    rm = {$urandom, $urandom, $urandom, $urandom};
    load_matrix(rm, 7, 0);
    do_reset();
    build_exp(tbl[0].m, tbl[0].rs, tbl[0].cs, tbl[0].tot, ex);
    load_matrix(tbl[0].m, 16, 0);
    collect(0, 25, 1'b0);
    compare("after_load_reset", ex, 25);

    for (int t = 0; t < 20; t++) begin
      rm = {$urandom, $urandom, $urandom, $urandom};
      if (t == 0) rm = {16{8'hFF}};
      model(rm, ex);
      load_matrix(rm, 16, 30);
      collect(2, 25, 1'($urandom_range(1)));
      compare($sformatf("random%0d", t), ex, 25);
    end

`ifdef ABFT_ENC_FAULT_INJ_EN
    build_exp(tbl[0].m, tbl[0].rs, tbl[0].cs, tbl[0].tot, ex);
    ex[0] = ex[0] ^ 14'd1;
    inj_en  = 1'b1;
    inj_idx = 5'd0;
    load_matrix(tbl[0].m, 16, 0);
    inj_en  = 1'b0;
    collect(0, 25, 1'b0);
    compare("inject_idx0", ex, 25);
    build_exp(tbl[0].m, tbl[0].rs, tbl[0].cs, tbl[0].tot, ex);
    load_matrix(tbl[0].m, 16, 0);
    collect(0, 25, 1'b0);
    compare("inject_off", ex, 25);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/abft_encoder.md
ABFT_ENCODER -- requirements
Module: abft_encoder

Interface
REQ-001 SHALL provide parameter N, default 4, matrix dimension (N x N data block).
REQ-002 SHALL provide parameter DW, default 8, input element width in bits.
REQ-003 SHALL derive local constant CW = DW + 2*clog2(N), default 12, output word width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  producer has an element on in_data.
REQ-007 in_data  input  DW  matrix element, row-major order.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 out_valid  output  1  out_data holds an encoded word.
REQ-010 out_data  output  CW  data element or checksum, zero-extended.
REQ-011 out_chk  output  1  current word is a checksum, not a data element.
REQ-012 out_last  output  1  current word is the final (grand-total) word.
REQ-013 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-014 SHALL count a transfer only when valid and ready are both high in the same cycle, on either port.
REQ-015 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-016 In LOAD, SHALL store each accepted element in an N*N buffer, add it to row sum[row] (DW+clog2(N) bits), column sum[col], and grand total (CW bits).
REQ-017 SHALL move LOAD->EMIT on the cycle of the N*N-th input transfer, asserting out_valid the next cycle (1-cycle latency).
REQ-018 In EMIT, SHALL output (N+1)*(N+1) words row-major: for each row r, N elements then row sum[r]; then final row of N column sums followed by the grand total.
REQ-019 SHALL assert out_chk on row-sum, column-sum and grand-total words only.
REQ-020 SHALL assert out_last only on the grand-total word.
REQ-021 SHALL hold out_data, out_chk and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL move EMIT->LOAD on the out_last transfer, clearing all sums and counters, with in_ready=1 the next cycle.
REQ-023 SHALL never overflow sums: widths are sized for all-ones inputs.
REQ-024 in_valid during EMIT SHALL be ignored; out_ready during LOAD SHALL be ignored.
REQ-025 Minimum period per matrix SHALL be N*N + (N+1)*(N+1) cycles (41 for defaults).

Reset
REQ-026 While rst=1 at a clock edge, SHALL enter LOAD, clear buffer index, sums and output counters.
REQ-027 Outputs the cycle after reset SHALL be: in_ready=1, out_valid=0, out_data=0, out_chk=0, out_last=0.
REQ-028 Reset in mid-LOAD or mid-EMIT SHALL discard the partial matrix; no further words of it are emitted.

Configuration
REQ-029 Macro ABFT_ENC_FAULT_INJ_EN SHALL, when defined, add inputs inj_en (1) and inj_idx (clog2((N+1)*(N+1)) bits), sampled on the last input transfer.
REQ-030 With the macro defined and inj_en sampled 1, SHALL invert bit 0 of the emitted word at index inj_idx; checksums stay computed from uncorrupted data.
REQ-031 Without the macro, ports SHALL be absent and output SHALL always be the exact encoding.

Structure
REQ-032 Package abft_pkg SHALL hold N, DW, CW defaults and the state enum {LOAD, EMIT}.
REQ-033 Sub-module abft_chk_acc SHALL implement one clearable, enabled checksum accumulator, instantiated for row, column and total sums.

Verification
REQ-034 Inputs 1..16, out_ready=1 -> rows [1 2 3 4 10][5 6 7 8 26][9 10 11 12 42][13 14 15 16 58], last row [28 32 36 40 136]; out_last on 136 only.
REQ-035 All inputs 255 -> every row/column sum 1020, grand total 4080, no wrap.
REQ-036 out_ready toggled 1/0 every cycle during EMIT -> identical 25-word sequence, out_data stable in every stalled cycle.
REQ-037 rst pulsed after 10 EMIT words -> out_valid=0 next cycle, in_ready=1; next matrix of all 1s emits sums 4, total 16.
REQ-038 Macro defined, inj_en=1, inj_idx=0, inputs 1..16 -> first word 0, row sum still 10; inj_en=0 -> exact encoding.
